// File: rtl/sprite_button.sv
// Bitmap sprite overlay for a VGA scan: 3-edge pipeline (hit/address, RAM read, output)
// with an optional blink mode that inverts the colour every BLINK_FRAMES frames.
module sprite_button #(
    parameter int RES_X        = 140,
    parameter int RES_Y        = 20,
    parameter int BLINK_FRAMES = 30,
    localparam int AW          = $clog2(RES_X * RES_Y)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic [9:0]    posx,
    input  logic [9:0]    posy,
    input  logic [9:0]    hcount,
    input  logic [9:0]    vcount,
    input  logic          selected,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [8:0]    wr_data,
    output logic [2:0]    red,
    output logic [2:0]    green,
    output logic [1:0]    blue,
    output logic          data
);

    localparam int          DEPTH      = RES_X * RES_Y;
    localparam logic [AW:0] DEPTH_W    = (AW+1)'(DEPTH);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [8:0]    r_mem [DEPTH];
    logic          r_vld_p1;
    logic [AW-1:0] r_addr_p1;
    logic          r_vld_p2;
    logic [8:0]    r_pix_p2;
    logic [7:0]    r_frame_cnt;
    logic          r_blink;
    logic [2:0]    r_red;
    logic [2:0]    r_green;
    logic [1:0]    r_blue;
    logic          r_data;

    logic [10:0]   w_xend;
    logic [10:0]   w_yend;
    logic [9:0]    w_dx;
    logic [9:0]    w_dy;
    logic          w_hit;
    logic [AW-1:0] w_addr;
    logic          w_frame_start;
    logic          w_opaque;
    logic [7:0]    w_colour;

    function automatic logic [7:0] blink_colour(input logic [7:0] pix, input logic invert);
        return invert ? ~pix : pix;
    endfunction

    // Extents in 11 bits so a sprite touching the right/bottom edge never wraps to 0.
    assign w_xend = {1'b0, posx} + 11'(RES_X);
    assign w_yend = {1'b0, posy} + 11'(RES_Y);
    assign w_hit  = enable && (hcount >= posx) && ({1'b0, hcount} < w_xend)
                           && (vcount >= posy) && ({1'b0, vcount} < w_yend);
    assign w_dx   = hcount - posx;
    assign w_dy   = vcount - posy;
    assign w_addr = w_hit ? (AW'(w_dy) * AW'(RES_X) + AW'(w_dx)) : '0;

    assign w_frame_start = (hcount == 10'd0) && (vcount == 10'd0);
    assign w_opaque      = r_vld_p2 && r_pix_p2[8];
    assign w_colour      = blink_colour(r_pix_p2[7:0], selected && r_blink);

    always_ff @(posedge clock) begin
        if (wr_en && ({1'b0, wr_addr} < DEPTH_W)) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Stage 1: hit test and bitmap address
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_hit;
        end
        r_addr_p1 <= w_addr;
    end

    // Stage 2: RAM read (old contents win on a same-edge write)
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p2 <= r_vld_p1;
        end
        r_pix_p2 <= r_mem[r_addr_p1];
    end

    // Stage 3: registered pixel output; colour holds on transparent/no-hit pixels
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data  <= 1'b0;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else begin
            r_data <= w_opaque;
            if (w_opaque) begin
                {r_red, r_green, r_blue} <= w_colour;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !selected) begin
            r_frame_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (w_frame_start) begin
            if (r_frame_cnt == BLINK_LAST) begin
                r_frame_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign red   = r_red;
    assign green = r_green;
    assign blue  = r_blue;
    assign data  = r_data;

endmodule
